// File: rtl/mcs4_bus_initiator.sv
// mcs4_bus_initiator: CPU-side master of the MCS-4 4-bit multiplexed bus.
// Sequences the 8-phase instruction cycle, drives the fetch address nibbles,
// captures the returned instruction byte and handles I/O and SRC data phases.
// Optional build macro: MCS4_BUS_TWO_WORD_EN enables two-word instruction
// tracking, which suppresses I/O and SRC decode on the second word.
module mcs4_bus_initiator #(
    parameter logic [3:0] IDLE_DBUS = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_addr,
    input  logic [3:0]  x2_data,
    input  logic [3:0]  x3_data,
    output logic        sync,
    output logic        cm_rom,
    output logic [3:0]  dbus_out,
    input  logic [3:0]  dbus_in,
    output logic [7:0]  instr,
    output logic        instr_valid,
    output logic        instr_word2,
    output logic [3:0]  io_rdata,
    output logic        io_rdata_valid
);

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_t;

    phase_t      phase_q, phase_d;
    logic [11:0] addr_q;
    logic [3:0]  opr_q;
    logic [7:0]  instr_q;
    logic        io_q;
    logic        src_q;
    logic [3:0]  io_rdata_q;
    logic        rd_valid_q;
    logic        suppress;
    logic        accept;
    logic        rd_capture;

    assign accept     = (phase_q == PH_X3) && req_valid;
    assign rd_capture = (phase_q == PH_X2) && io_q && instr_q[3];

`ifdef MCS4_BUS_TWO_WORD_EN
    logic w2_q;   // current bus cycle carries the second word of an instruction
    logic tw_q;   // byte just fetched is the first word of a two-word instruction
    logic is_two_word;

    assign is_two_word = (opr_q == 4'h1) || (opr_q == 4'h4) || (opr_q == 4'h5) ||
                         (opr_q == 4'h7) || ((opr_q == 4'h2) && !dbus_in[0]);
    assign suppress    = w2_q;
    assign instr_word2 = instr_valid && w2_q;

    // Two-word tracking: classify at the end of M2, hand over at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            w2_q <= 1'b0;
            tw_q <= 1'b0;
        end else begin
            if (phase_q == PH_M2) tw_q <= !w2_q && is_two_word;
            if (accept)           w2_q <= tw_q;
        end
    end
`else
    assign suppress    = 1'b0;
    assign instr_word2 = 1'b0;
`endif

    // Phase sequencing: free-running through the cycle, parking in X3 until a request.
    always_comb begin
        phase_d = phase_t'(phase_q + 3'd1);
        if (phase_q == PH_X3) phase_d = req_valid ? PH_A1 : PH_X3;
    end

    // Cycle state, fetched byte, decode flags and I/O read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= PH_X3;
            addr_q     <= 12'h000;
            opr_q      <= 4'h0;
            instr_q    <= 8'h00;
            io_q       <= 1'b0;
            src_q      <= 1'b0;
            io_rdata_q <= 4'h0;
            rd_valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            if (accept) addr_q <= req_addr;
            if (phase_q == PH_M1) opr_q <= dbus_in;
            if (phase_q == PH_M2) begin
                instr_q <= {opr_q, dbus_in};
                io_q    <= (opr_q == 4'hE) && !suppress;
                src_q   <= (opr_q == 4'h2) && dbus_in[0] && !suppress;
            end else if (phase_q == PH_X3) begin
                // Clearing here keeps stall cycles after X3 on the idle nibble.
                io_q  <= 1'b0;
                src_q <= 1'b0;
            end
            if (rd_capture) io_rdata_q <= dbus_in;
            rd_valid_q <= rd_capture;
        end
    end

    // Bus drive, command line and per-phase strobes.
    always_comb begin
        sync        = 1'b0;
        cm_rom      = 1'b0;
        dbus_out    = IDLE_DBUS;
        req_ready   = 1'b0;
        instr_valid = 1'b0;
        if (rst) begin
            sync = 1'b1;
        end else begin
            case (phase_q)
                PH_A1: dbus_out = addr_q[3:0];
                PH_A2: dbus_out = addr_q[7:4];
                PH_A3: dbus_out = addr_q[11:8];
                PH_M2: cm_rom   = (opr_q == 4'hE) && !suppress;
                PH_X1: instr_valid = 1'b1;
                PH_X2: begin
                    if (src_q) begin
                        cm_rom   = 1'b1;
                        dbus_out = x2_data;
                    end else if (io_q && !instr_q[3]) begin
                        dbus_out = x2_data;
                    end
                end
                PH_X3: begin
                    sync      = 1'b1;
                    req_ready = 1'b1;
                    if (src_q) dbus_out = x3_data;
                end
                default: ;
            endcase
        end
    end

    assign instr          = instr_q;
    assign io_rdata       = io_rdata_q;
    assign io_rdata_valid = rd_valid_q;

endmodule

// File: tb/tb_mcs4_bus_initiator.sv
// Directed bench for mcs4_bus_initiator with a scoreboard of expected
// instruction bytes and I/O read nibbles.
module tb_mcs4_bus_initiator;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic [3:0]  x2_data;
    logic [3:0]  x3_data;
    logic        sync;
    logic        cm_rom;
    logic [3:0]  dbus_out;
    logic [3:0]  dbus_in;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        instr_word2;
    logic [3:0]  io_rdata;
    logic        io_rdata_valid;

    int tests = 0;
    int fails = 0;
    bit tb_w2 = 1'b0;
    logic [7:0] exp_instr_q[$];
    logic [3:0] exp_rd_q[$];

    mcs4_bus_initiator #(.IDLE_DBUS(4'h0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .x2_data(x2_data), .x3_data(x3_data),
        .sync(sync), .cm_rom(cm_rom), .dbus_out(dbus_out), .dbus_in(dbus_in),
        .instr(instr), .instr_valid(instr_valid), .instr_word2(instr_word2),
        .io_rdata(io_rdata), .io_rdata_valid(io_rdata_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full bus cycle, entered and left in X3.
    task automatic run_cycle(input logic [11:0] a, input logic [7:0] b,
                             input logic [3:0] x2, input logic [3:0] x3, input logic [3:0] rd);
        logic [3:0] opr, opa;
        bit io, src, exp_rd, w2;
        logic [3:0] exp_x2_dbus;
        logic exp_x2_cm;
        opr = b[7:4];
        opa = b[3:0];
`ifdef MCS4_BUS_TWO_WORD_EN
        w2 = tb_w2;
`else
        w2 = 1'b0;
`endif
        io     = !w2 && (opr == 4'hE);
        src    = !w2 && (opr == 4'h2) && opa[0];
        exp_rd = io && opa[3];
        exp_x2_cm   = src;
        exp_x2_dbus = (src || (io && !opa[3])) ? x2 : 4'h0;

        check("x3_ready", {11'd0, req_ready}, 12'd1);
        check("x3_sync",  {11'd0, sync}, 12'd1);
        req_valid = 1'b1;
        req_addr  = a;
        exp_instr_q.push_back(b);
        tick(); // A1
        req_valid = 1'b0;
        req_addr  = ~a;
        check("a1_sync",  {11'd0, sync}, 12'd0);
        check("a1_ready", {11'd0, req_ready}, 12'd0);
        check("a1_dbus",  {8'd0, dbus_out}, {8'd0, a[3:0]});
        tick(); // A2
        check("a2_dbus",  {8'd0, dbus_out}, {8'd0, a[7:4]});
        tick(); // A3
        check("a3_dbus",  {8'd0, dbus_out}, {8'd0, a[11:8]});
        check("a3_cm",    {11'd0, cm_rom}, 12'd0);
        tick(); // M1
        dbus_in = opr;
        check("m1_cm",    {11'd0, cm_rom}, 12'd0);
        tick(); // M2
        dbus_in = opa;
        check("m2_cm",    {11'd0, cm_rom}, {11'd0, io});
        tick(); // X1
        dbus_in = 4'h0;
        x2_data = x2;
        x3_data = x3;
        check("x1_valid", {11'd0, instr_valid}, 12'd1);
        check("x1_word2", {11'd0, instr_word2}, {11'd0, w2});
        check("x1_cm",    {11'd0, cm_rom}, 12'd0);
        if (exp_instr_q.size() > 0) check("instr", {4'd0, instr}, {4'd0, exp_instr_q.pop_front()});
        if (exp_rd) exp_rd_q.push_back(rd);
        tick(); // X2
        dbus_in = rd;
        check("x2_valid", {11'd0, instr_valid}, 12'd0);
        check("x2_dbus",  {8'd0, dbus_out}, {8'd0, exp_x2_dbus});
        check("x2_cm",    {11'd0, cm_rom}, {11'd0, exp_x2_cm});
        tick(); // X3
        dbus_in = 4'h0;
        check("x3_sync2", {11'd0, sync}, 12'd1);
        check("x3_dbus",  {8'd0, dbus_out}, {8'd0, src ? x3 : 4'h0});
        check("x3_cm",    {11'd0, cm_rom}, 12'd0);
        check("x3_rdv",   {11'd0, io_rdata_valid}, {11'd0, exp_rd});
        if (io_rdata_valid && exp_rd_q.size() > 0)
            check("io_rdata", {8'd0, io_rdata}, {8'd0, exp_rd_q.pop_front()});
        tb_w2 = !w2 && ((opr == 4'h1) || (opr == 4'h4) || (opr == 4'h5) ||
                        (opr == 4'h7) || ((opr == 4'h2) && !opa[0]));
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = 12'h000;
        x2_data = 4'h0;
        x3_data = 4'h0;
        dbus_in = 4'h0;

        // Reset state
        tick();
        check("rst_sync", {11'd0, sync}, 12'd1);
        check("rst_cm",   {11'd0, cm_rom}, 12'd0);
        check("rst_dbus", {8'd0, dbus_out}, 12'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_instr", {4'd0, instr}, 12'd0);
        check("rst_iv",    {11'd0, instr_valid}, 12'd0);
        check("rst_rdv",   {11'd0, io_rdata_valid}, 12'd0);
        check("rst_iord",  {8'd0, io_rdata}, 12'd0);

        // Stall with no request
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_sync", {11'd0, sync}, 12'd1);
            check("stall_dbus", {8'd0, dbus_out}, 12'd0);
            check("stall_cm",   {11'd0, cm_rom}, 12'd0);
        end

        // Back-to-back fetches: plain, WRR, RDR, SRC
        run_cycle(12'h3A5, 8'hD7, 4'h0, 4'h0, 4'h0);
        run_cycle(12'h012, 8'hE2, 4'h9, 4'h0, 4'h0);
        run_cycle(12'h013, 8'hEA, 4'h0, 4'h0, 4'h6);
        run_cycle(12'h014, 8'h25, 4'h3, 4'hC, 4'h0);

        // Two-word instruction followed by an I/O opcode byte
        run_cycle(12'h100, 8'h40, 4'h0, 4'h0, 4'h0);
        run_cycle(12'h101, 8'hE2, 4'h5, 4'h0, 4'h0);

        // Stall after SRC: X3 data must not persist into stall cycles
        run_cycle(12'h200, 8'h23, 4'hA, 4'h7, 4'h0);
        tick();
        check("post_src_stall_dbus", {8'd0, dbus_out}, 12'd0);
        check("post_src_stall_sync", {11'd0, sync}, 12'd1);

        // Two-word byte, then abort the next cycle with reset in M1
        run_cycle(12'h300, 8'h50, 4'h0, 4'h0, 4'h0);
        req_valid = 1'b1;
        req_addr  = 12'h301;
        tick(); // A1
        req_valid = 1'b0;
        tick(); // A2
        tick(); // A3
        tick(); // M1
        dbus_in = 4'hE;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dbus_in = 4'h0;
        tb_w2 = 1'b0;
        check("abort_sync", {11'd0, sync}, 12'd1);
        check("abort_cm",   {11'd0, cm_rom}, 12'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort_iv",   {11'd0, instr_valid}, 12'd0);
            check("abort_rdv",  {11'd0, io_rdata_valid}, 12'd0);
            check("abort_sync2", {11'd0, sync}, 12'd1);
        end
        check("abort_instr", {4'd0, instr}, 12'd0);

        // Recovery: tracking flag cleared by reset, so I/O decodes normally
        run_cycle(12'hFFF, 8'hEA, 4'h0, 4'h0, 4'hB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mcs4_bus_initiator.md
Name: mcs4_bus_initiator

Overview:
- CPU-side master of the MCS-4 4-bit multiplexed bus. It is the initiator that i4001-style ROM/IO responders track.
- Generates the 8-phase instruction cycle and the sync pulse. Drives the 12-bit fetch address as three nibbles and captures the returned instruction byte.
- Decodes OPR for I/O (0xE) and SRC (0x2, odd OPA) to drive cm_rom and the X2/X3 data, and captures read data at X2.
- Sits between the 4004 core's PC/decoder and the shared data bus.

Parameters:
- IDLE_DBUS, 4'h0, nibble driven on dbus_out in every phase where the initiator does not own the bus.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- req_valid  in  1  core has the next fetch address.
- req_ready  out  1  high only in phase X3; a transfer happens when req_valid && req_ready.
- req_addr  in  12  fetch address; latched on acceptance.
- x2_data  in  4  SRC high nibble or I/O write data; sampled live during X2.
- x3_data  in  4  SRC low nibble; sampled live during X3.
- sync  out  1  bus sync; high in X3 and in every stall cycle.
- cm_rom  out  1  ROM command line.
- dbus_out  out  4  bus drive nibble.
- dbus_in  in  4  bus receive nibble (OR of responders).
- instr  out  8  fetched byte {OPR,OPA}.
- instr_valid  out  1  one-cycle pulse in X1 when instr updates.
- instr_word2  out  1  qualifies instr_valid; see Optional Feature.
- io_rdata  out  4  data captured at end of X2 for I/O reads.
- io_rdata_valid  out  1  one-cycle pulse in X3 after a read capture.

Behaviour:
- Phase register (3 bits) encodes A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7. It advances by 1 per clk, except in X3.
- In X3: if req_valid, latch req_addr and go to A1. Otherwise stay in X3 (stall).
- Stall cycles: sync=1, cm_rom=0, dbus_out=IDLE_DBUS. Responders reset their counters each stall cycle and so realign to A1 on the cycle after acceptance.
- Reset: phase=X3, addr=0, instr=8'h00, io_rdata=0, all pulses 0. Outputs during reset: sync=1, cm_rom=0, dbus_out=IDLE_DBUS. Reset asserted mid-cycle aborts the cycle; no instr_valid or io_rdata_valid is emitted for it.
- Address drive: A1 drives addr[3:0], A2 drives addr[7:4], A3 drives addr[11:8] (chip ID).
- Instruction capture:
  - OPR register <= dbus_in at the clk edge ending M1.
  - OPA register <= dbus_in at the clk edge ending M2.
  - instr_valid=1 during X1 only.
- I/O decode:
  - cm_rom=1 during M2 iff the OPR register == 4'hE. This is combinational from the register captured at the end of M1.
  - An io flag is registered at the end of M2.
- X2 with io flag set:
  - OPA[3]=0 (write group, e.g. WRR=0x2): dbus_out=x2_data, cm_rom=0.
  - OPA[3]=1 (read group, e.g. RDR=0xA): dbus_out=IDLE_DBUS, io_rdata <= dbus_in at the end of X2, io_rdata_valid=1 in X3.
- SRC: when OPR==4'h2 and OPA[0]==1:
  - X2: cm_rom=1, dbus_out=x2_data.
  - X3: dbus_out=x3_data, cm_rom=0.
  - sync remains 1 in X3.
- All other phases: dbus_out=IDLE_DBUS, cm_rom=0.
- Back-to-back cycles: a request accepted in X3 yields A1 on the next clk, giving a period of exactly 8 clocks with no bubble.
- req_addr changing after acceptance has no effect.

Optional Feature:
- Macro: MCS4_BUS_TWO_WORD_EN.
- Defined:
  - Two-word OPRs are tracked: 0x1 JCN, 0x2 with even OPA (FIM), 0x4 JUN, 0x5 JMS, 0x7 ISZ.
  - In the following bus cycle, the I/O and SRC decodes are suppressed: no cm_rom in M2/X2 and no X2/X3 data drive.
  - instr_word2=1 with that cycle's instr_valid.
  - Reset clears the tracking flag.
- Undefined: every fetched byte is decoded and instr_word2 is tied 0. The port list is unchanged.

Test Plan:
- Fetch 12'h3A5 with responder returning 8'hD7 → dbus_out 5, A, 3 in A1–A3. instr=8'hD7 with instr_valid in X1. cm_rom never high. sync high only in X3.
- req_valid low for 5 cycles after reset, then high → 5+ cycles of sync=1 and dbus_out=0, then A1 on the cycle after acceptance. Period thereafter is exactly 8 with req_valid held.
- Fetch returns 8'hE2 (WRR), x2_data=4'h9 → cm_rom=1 in M2 only; dbus_out=9 in X2; io_rdata_valid stays 0.
- Fetch returns 8'hEA (RDR), responder drives 4'h6 at X2 → cm_rom in M2, io_rdata=6 and io_rdata_valid=1 in X3.
- Fetch returns 8'h25 (SRC), x2_data=4'h3, x3_data=4'hC → cm_rom=1 and dbus=3 in X2; dbus=C in X3.
- With MCS4_BUS_TWO_WORD_EN: fetch 8'h40 then 8'hE2 → second cycle has instr_word2=1 and no cm_rom. Reset asserted in M1 → no instr_valid; phase returns to X3 with sync=1.
